ls_coef_solver: RTL and testbench

- Downstream stage of the 3x3 normal-matrix inverter in the option-pricing regression path.
- Computes the quadratic regression coefficients beta = inv(XTX) * XTY.
- Inputs are the 6 unique entries of the symmetric inverse, the 3-element XTY vector, and a singular flag.
- Uses one time-multiplexed signed multiplier with a MAC accumulator and a valid/ready handshake on both sides.

---
 rtl/ls_coef_solver_if.sv | 66 ++++++
 rtl/ls_coef_solver.sv | 215 +++++++++++++++++++++
 tb/tb_ls_coef_solver.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ls_coef_solver_if.sv
// ---------------------------------------------------------------------------
// ls_coef_solver_if
// Handshake and data bundle for the least-squares coefficient solver.
//
// Upstream side (producer -> solver):
//   in_valid, in_ready       input set handshake
//   inv00..inv22             6 unique entries of the symmetric 3x3 inverse
//   xty0..xty2               XTY vector (sum y, sum x*y, sum x^2*y)
//   in_singular              upstream determinant was zero
// Downstream side (solver -> consumer):
//   out_valid, out_ready     result handshake
//   beta0..beta2             signed regression coefficients
//   out_err                  result came from a singular input
//
// Modports:
//   master : the environment that feeds inputs and consumes results
//   slave  : the solver itself
// ---------------------------------------------------------------------------
interface ls_coef_solver_if #(
  parameter int INV_W = 32,
  parameter int XTY_W = 24,
  parameter int OUT_W = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [INV_W-1:0] inv00;
  logic signed [INV_W-1:0] inv01;
  logic signed [INV_W-1:0] inv02;
  logic signed [INV_W-1:0] inv11;
  logic signed [INV_W-1:0] inv12;
  logic signed [INV_W-1:0] inv22;
  logic signed [XTY_W-1:0] xty0;
  logic signed [XTY_W-1:0] xty1;
  logic signed [XTY_W-1:0] xty2;
  logic                    in_singular;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] beta0;
  logic signed [OUT_W-1:0] beta1;
  logic signed [OUT_W-1:0] beta2;
  logic                    out_err;

  modport master (
    output in_valid,
    output inv00, inv01, inv02, inv11, inv12, inv22,
    output xty0, xty1, xty2,
    output in_singular,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  beta0, beta1, beta2,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  inv00, inv01, inv02, inv11, inv12, inv22,
    input  xty0, xty1, xty2,
    input  in_singular,
    input  out_ready,
    output in_ready,
    output out_valid,
    output beta0, beta1, beta2,
    output out_err
  );
endinterface

// File: rtl/ls_coef_solver.sv
// ---------------------------------------------------------------------------
// ls_coef_solver
// Computes beta = inv(XTX) * XTY for the quadratic regression path using a
// single time-multiplexed signed multiplier feeding a MAC accumulator.
// Nine products are formed, one per cycle, column-inner / row-outer; at the
// end of each row the accumulated sum is rounded (half toward +inf), shifted
// down by INV_FRAC fractional bits and saturated to OUT_W.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   ls_coef_solver_if.slave: input set handshake (inverse entries,
//         XTY vector, singular flag) and result handshake (betas, error)
// ---------------------------------------------------------------------------
module ls_coef_solver #(
  parameter int INV_W    = 32,
  parameter int INV_FRAC = 16,
  parameter int XTY_W    = 24,
  parameter int OUT_W    = 32,
  parameter int ACC_W    = INV_W + XTY_W + 2
) (
  input  logic               clk,
  input  logic               rst,
  ls_coef_solver_if.slave    bus
);

  localparam int PROD_W = INV_W + XTY_W;
  localparam int RND_W  = ACC_W + 1;

  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(1) << (INV_FRAC - 1);
  localparam logic signed [OUT_W-1:0] OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              row_q, row_d;
  logic [1:0]              col_q, col_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [INV_W-1:0] inv_q [0:5];
  logic signed [INV_W-1:0] inv_d [0:5];
  logic signed [XTY_W-1:0] xty_q [0:2];
  logic signed [XTY_W-1:0] xty_d [0:2];
  logic signed [OUT_W-1:0] beta_q [0:2];
  logic signed [OUT_W-1:0] beta_d [0:2];
  logic                    err_q, err_d;
  logic                    valid_q, valid_d;

  logic signed [INV_W-1:0]  coef;
  logic signed [XTY_W-1:0]  xsel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [RND_W-1:0]  rnd;
  logic signed [RND_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  satv;

  // Operand select for the shared multiplier. The inverse is symmetric, so
  // only 6 entries are stored: index 0..5 = inv00, inv01, inv02, inv11,
  // inv12, inv22, and mirrored (row, col) pairs map to the same slot.
  always_comb begin
    coef = inv_q[0];
    case ({row_q, col_q})
      4'b00_00: coef = inv_q[0];
      4'b00_01: coef = inv_q[1];
      4'b00_10: coef = inv_q[2];
      4'b01_00: coef = inv_q[1];
      4'b01_01: coef = inv_q[3];
      4'b01_10: coef = inv_q[4];
      4'b10_00: coef = inv_q[2];
      4'b10_01: coef = inv_q[4];
      4'b10_10: coef = inv_q[5];
      default:  coef = inv_q[0];
    endcase

    xsel = xty_q[0];
    case (col_q)
      2'd0:    xsel = xty_q[0];
      2'd1:    xsel = xty_q[1];
      2'd2:    xsel = xty_q[2];
      default: xsel = xty_q[0];
    endcase
  end

  // Multiply, accumulate, round and saturate. The rounding add is done one
  // bit wider than the accumulator so a near-full-scale sum cannot wrap
  // before the shift.
  always_comb begin
    prod    = PROD_W'(coef) * PROD_W'(xsel);
    sum     = acc_q + ACC_W'(prod);
    rnd     = RND_W'(sum) + RND_HALF;
    shifted = rnd >>> INV_FRAC;
    if (shifted > RND_W'(OUT_MAX)) begin
      satv = OUT_MAX;
    end else if (shifted < RND_W'(OUT_MIN)) begin
      satv = OUT_MIN;
    end else begin
      satv = shifted[OUT_W-1:0];
    end
  end

  // Next-state and datapath update. The singular path enters DONE with
  // out_valid still low and raises it one cycle later, so a singular result
  // is presented one cycle after acceptance; the MAC path raises out_valid
  // on the same edge as its ninth product.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    inv_d   = inv_q;
    xty_d   = xty_q;
    beta_d  = beta_q;
    err_d   = err_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          inv_d[0] = bus.inv00;
          inv_d[1] = bus.inv01;
          inv_d[2] = bus.inv02;
          inv_d[3] = bus.inv11;
          inv_d[4] = bus.inv12;
          inv_d[5] = bus.inv22;
          xty_d[0] = bus.xty0;
          xty_d[1] = bus.xty1;
          xty_d[2] = bus.xty2;
          if (bus.in_singular) begin
            beta_d[0] = '0;
            beta_d[1] = '0;
            beta_d[2] = '0;
            err_d     = 1'b1;
            state_d   = DONE;
          end else begin
            err_d   = 1'b0;
            row_d   = 2'd0;
            col_d   = 2'd0;
            acc_d   = '0;
            state_d = MAC;
          end
        end
      end

      MAC: begin
        if (col_q == 2'd2) begin
          beta_d[row_q] = satv;
          acc_d         = '0;
          col_d         = 2'd0;
          if (row_q == 2'd2) begin
            row_d   = 2'd0;
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          acc_d = sum;
          col_d = col_q + 2'd1;
        end
      end

      DONE: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register. Reset clears everything, including a half-finished MAC,
  // so a partial result can never be presented as valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      acc_q   <= '0;
      inv_q   <= '{default: '0};
      xty_q   <= '{default: '0};
      beta_q  <= '{default: '0};
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      inv_q   <= inv_d;
      xty_q   <= xty_d;
      beta_q  <= beta_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = valid_q;
  assign bus.beta0     = beta_q[0];
  assign bus.beta1     = beta_q[1];
  assign bus.beta2     = beta_q[2];
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_ls_coef_solver.sv
// ---------------------------------------------------------------------------
// tb_ls_coef_solver
// Directed testbench for ls_coef_solver. Drives input sets through the
// interface, measures output latency and compares betas/error flag against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_ls_coef_solver;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   lat;

  always #5 clk = ~clk;

  ls_coef_solver_if bus ();

  ls_coef_solver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One comparison: count it, and on mismatch count a failure and report.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one input set (called at posedge+1) and hold it across the
  // accepting edge, then drop in_valid.
  task automatic applyStimulus(input int i00, input int i01, input int i02,
                               input int i11, input int i12, input int i22,
                               input int x0, input int x1, input int x2,
                               input logic sing);
    bus.inv00       = i00;
    bus.inv01       = i01;
    bus.inv02       = i02;
    bus.inv11       = i11;
    bus.inv12       = i12;
    bus.inv22       = i22;
    bus.xty0        = 24'(x0);
    bus.xty1        = 24'(x1);
    bus.xty2        = 24'(x2);
    bus.in_singular = sing;
    bus.in_valid    = 1'b1;
    checkOutput("in_ready_before_accept", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    bus.in_singular = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid is seen, bounded.
  task automatic waitValid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Full transaction with out_ready already high: latency, results, then
  // the handshake edge and return to IDLE.
  task automatic runVector(input string name,
                           input int i00, input int i01, input int i02,
                           input int i11, input int i12, input int i22,
                           input int x0, input int x1, input int x2,
                           input logic sing, input int expLat,
                           input int eb0, input int eb1, input int eb2,
                           input logic eerr);
    int cyc;
    applyStimulus(i00, i01, i02, i11, i12, i22, x0, x1, x2, sing);
    waitValid(cyc);
    checkOutput({name, "_latency"}, 64'(cyc), 64'(expLat));
    checkOutput({name, "_beta0"}, 64'(bus.beta0), 64'(eb0));
    checkOutput({name, "_beta1"}, 64'(bus.beta1), 64'(eb1));
    checkOutput({name, "_beta2"}, 64'(bus.beta2), 64'(eb2));
    checkOutput({name, "_err"}, 64'(bus.out_err), 64'(eerr));
    @(posedge clk);
    #1;
    checkOutput({name, "_valid_after_hs"}, 64'(bus.out_valid), 64'(0));
    checkOutput({name, "_ready_after_hs"}, 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_singular = 1'b0;
    bus.out_ready   = 1'b0;
    bus.inv00 = '0; bus.inv01 = '0; bus.inv02 = '0;
    bus.inv11 = '0; bus.inv12 = '0; bus.inv22 = '0;
    bus.xty0  = '0; bus.xty1  = '0; bus.xty2  = '0;

    // Reset state
    #12;
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(1));
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("rst_beta0", 64'(bus.beta0), 64'(0));
    checkOutput("rst_out_err", 64'(bus.out_err), 64'(0));
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;

    // Identity inverse: beta = xty
    runVector("identity", 65536, 0, 0, 65536, 0, 65536, 5, -7, 100, 1'b0, 9, 5, -7, 100, 1'b0);

    // Cross terms: row0 = 0.5*4 + 0.25*8, row1 = 0.25*4
    runVector("cross", 32768, 16384, 0, 0, 0, 0, 4, 8, 0, 1'b0, 9, 4, 1, 0, 1'b0);

    // Rounding half toward +inf: 1.5 -> 2, -1.5 -> -1, 0 -> 0
    runVector("round_pos", 32768, 0, 0, 0, 0, 0, 3, 0, 0, 1'b0, 9, 2, 0, 0, 1'b0);
    runVector("round_neg", 32768, 0, 0, 0, 0, 0, -3, 0, 0, 1'b0, 9, -1, 0, 0, 1'b0);
    runVector("round_zero", 32768, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 9, 0, 0, 0, 1'b0);

    // Saturation at both ends of the output range
    runVector("sat_pos", 32'h7FFFFFFF, 0, 0, 0, 0, 0, 8388607, 0, 0, 1'b0, 9, 32'h7FFFFFFF, 0, 0, 1'b0);
    runVector("sat_neg", 32'h7FFFFFFF, 0, 0, 0, 0, 0, -8388608, 0, 0, 1'b0, 9, 32'h80000000, 0, 0, 1'b0);

    // Singular input: zero betas, error flag, one-cycle latency
    runVector("singular", 65536, 100, 200, 65536, 300, 65536, 11, 22, 33, 1'b1, 1, 0, 0, 0, 1'b1);

    // Backpressure: hold out_ready low in DONE while in_valid toggles
    bus.out_ready = 1'b0;
    applyStimulus(32768, 16384, 0, 0, 0, 0, 4, 8, 0, 1'b0);
    waitValid(lat);
    checkOutput("bp_latency", 64'(lat), 64'(9));
    bus.inv00 = 65536; bus.inv11 = 65536; bus.inv22 = 65536;
    bus.xty0 = 24'(9); bus.xty1 = 24'(9); bus.xty2 = 24'(9);
    bus.in_singular = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", 64'(bus.out_valid), 64'(1));
      checkOutput("bp_in_ready", 64'(bus.in_ready), 64'(0));
      checkOutput("bp_beta0", 64'(bus.beta0), 64'(4));
      checkOutput("bp_beta1", 64'(bus.beta1), 64'(1));
      checkOutput("bp_beta2", 64'(bus.beta2), 64'(0));
      checkOutput("bp_err", 64'(bus.out_err), 64'(0));
    end
    bus.in_valid    = 1'b0;
    bus.in_singular = 1'b0;
    bus.out_ready   = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_valid_after_hs", 64'(bus.out_valid), 64'(0));
    checkOutput("bp_ready_after_hs", 64'(bus.in_ready), 64'(1));
    checkOutput("bp_beta0_after_hs", 64'(bus.beta0), 64'(4));

    // Reset mid-MAC: previous betas visible until row completion, then abort
    applyStimulus(65536, 0, 0, 65536, 0, 65536, 11, -2, 3, 1'b0);
    checkOutput("mac1_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("mac1_in_ready", 64'(bus.in_ready), 64'(0));
    checkOutput("mac1_beta0_prev", 64'(bus.beta0), 64'(4));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mac4_beta0_row_done", 64'(bus.beta0), 64'(11));
    checkOutput("mac4_beta1_prev", 64'(bus.beta1), 64'(1));
    checkOutput("mac4_out_valid", 64'(bus.out_valid), 64'(0));
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("abort_in_ready", 64'(bus.in_ready), 64'(1));
    checkOutput("abort_beta0", 64'(bus.beta0), 64'(0));
    checkOutput("abort_beta1", 64'(bus.beta1), 64'(0));
    checkOutput("abort_beta2", 64'(bus.beta2), 64'(0));
    checkOutput("abort_err", 64'(bus.out_err), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fresh identity run after the abort
    runVector("post_reset", 65536, 0, 0, 65536, 0, 65536, 11, -2, 3, 1'b0, 9, 11, -2, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
